reg_file_2r1w: RTL and testbench

- Parametrised successor to the team's 8x8-bit register file.
- WIDTH x DEPTH storage with one write port and two independent registered read ports.
- Adds a per-port read-valid strobe, configurable write-to-read bypass, and a hardware clear sequencer with a BUSY flag.
- Sits behind the bus interface as the general-purpose register bank for the micro datapath.

---
 rtl/reg_file_2r1w.sv | 204 ++++++++++++++++++++
 tb/tb_reg_file_2r1w.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// WIDTH x DEPTH register bank: one write port, two registered read ports, optional
// write-to-read bypass, and a clear sweep with BUSY. Optional parity: REG_FILE_PARITY_EN.
module reg_file_2r1w #(
  parameter int   WIDTH  = 8,
  parameter int   DEPTH  = 8,
  parameter bit   BYPASS = 1'b1,
  localparam int  AW     = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WEN,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] DIN,
  input  logic             REN0,
  input  logic [AW-1:0]    RADDR0,
  output logic [WIDTH-1:0] DOUT0,
  output logic             RVALID0,
  input  logic             REN1,
  input  logic [AW-1:0]    RADDR1,
  output logic [WIDTH-1:0] DOUT1,
  output logic             RVALID1,
  input  logic             CLR,
  output logic             BUSY
`ifdef REG_FILE_PARITY_EN
  ,
  output logic             PERR0,
  output logic             PERR1
`endif
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam bit            POW2 = (DEPTH == (1 << AW));

  state_t          state_reg, state_next;
  logic [AW-1:0]   ptr_reg, ptr_next;
  logic            idle, sweep, wr_en, wr_ok;
  logic [1:0]      ren, rd_ok;
  logic [AW-1:0]   raddr [2];
  logic [WIDTH-1:0] entry_data [DEPTH];
  logic [WIDTH-1:0] dout [2];
  logic [1:0]      rvalid;
`ifdef REG_FILE_PARITY_EN
  logic            entry_par [DEPTH];
  logic [1:0]      perr;
`endif

  assign ren      = {REN1, REN0};
  assign raddr[0] = RADDR0;
  assign raddr[1] = RADDR1;
  assign idle     = (state_reg == IDLE);
  assign sweep    = (state_reg == SWEEP);
  // A clear request in the same cycle takes precedence over the write.
  assign wr_en    = idle && WEN && !CLR && wr_ok;

  // Address range checks only exist when DEPTH leaves unused address codes.
  if (POW2) begin : g_full_range
    assign wr_ok = 1'b1;
    assign rd_ok = 2'b11;
  end else begin : g_part_range
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    assign wr_ok = ({1'b0, WADDR} < DEPTH_W);
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_ok
      assign rd_ok[gi] = ({1'b0, raddr[gi]} < DEPTH_W);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (CLR) begin
          state_next = SWEEP;
          ptr_next   = '0;
        end
      end
      SWEEP: begin
        if (ptr_reg == LAST) begin
          state_next = IDLE;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  assign BUSY = sweep;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] data_reg;
    logic             clr_hit, wr_hit;
`ifdef REG_FILE_PARITY_EN
    logic             par_reg;
`endif

    assign clr_hit = sweep && (ptr_reg == AW'(gi));
    assign wr_hit  = wr_en && (WADDR == AW'(gi));

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        data_reg <= '0;
`ifdef REG_FILE_PARITY_EN
        par_reg  <= 1'b0;
`endif
      end else if (clr_hit) begin
        data_reg <= '0;
`ifdef REG_FILE_PARITY_EN
        par_reg  <= 1'b0;
`endif
      end else if (wr_hit) begin
        data_reg <= DIN;
`ifdef REG_FILE_PARITY_EN
        par_reg  <= ^DIN;
`endif
      end
    end

    assign entry_data[gi] = data_reg;
`ifdef REG_FILE_PARITY_EN
    assign entry_par[gi]  = par_reg;
`endif
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [WIDTH-1:0] dout_reg, data_next;
    logic             rvalid_reg, take, fwd;
`ifdef REG_FILE_PARITY_EN
    logic             perr_reg, perr_next;
`endif

    assign take = idle && ren[gi];
    assign fwd  = BYPASS && wr_en && (WADDR == raddr[gi]);

    always_comb begin
      data_next = '0;
      if (fwd) begin
        data_next = DIN;
      end else if (rd_ok[gi]) begin
        data_next = entry_data[raddr[gi]];
      end
    end

`ifdef REG_FILE_PARITY_EN
    // Forwarded and out-of-range data never carries a stored parity to check.
    always_comb begin
      perr_next = 1'b0;
      if (!fwd && rd_ok[gi]) begin
        perr_next = ^{entry_data[raddr[gi]], entry_par[raddr[gi]]};
      end
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        dout_reg   <= '0;
        rvalid_reg <= 1'b0;
`ifdef REG_FILE_PARITY_EN
        perr_reg   <= 1'b0;
`endif
      end else begin
        rvalid_reg <= take;
        if (take) begin
          dout_reg <= data_next;
        end
`ifdef REG_FILE_PARITY_EN
        perr_reg <= take ? perr_next : 1'b0;
`endif
      end
    end

    assign dout[gi]   = dout_reg;
    assign rvalid[gi] = rvalid_reg;
`ifdef REG_FILE_PARITY_EN
    assign perr[gi]   = perr_reg;
`endif
  end

  assign DOUT0   = dout[0];
  assign DOUT1   = dout[1];
  assign RVALID0 = rvalid[0];
  assign RVALID1 = rvalid[1];
`ifdef REG_FILE_PARITY_EN
  assign PERR0   = perr[0];
  assign PERR1   = perr[1];
`endif

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench: two instances (DEPTH=8 BYPASS=1, DEPTH=6 BYPASS=0) share the
// stimulus; expected reads are queued per instance/port and popped on RVALID.
module tb_reg_file_2r1w;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wen = 1'b0, ren0 = 1'b0, ren1 = 1'b0, clr = 1'b0;
  logic [2:0] waddr = '0, raddr0 = '0, raddr1 = '0;
  logic [7:0] din = '0;

  logic [7:0] a_dout0, a_dout1, b_dout0, b_dout1;
  logic       a_rvalid0, a_rvalid1, b_rvalid0, b_rvalid1, a_busy, b_busy;
`ifdef REG_FILE_PARITY_EN
  logic       a_perr0, a_perr1, b_perr0, b_perr1;
`else
  logic       a_perr0 = 1'b0, a_perr1 = 1'b0, b_perr0 = 1'b0, b_perr1 = 1'b0;
`endif

  exp_t q0[$], q1[$], q2[$], q3[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  reg_file_2r1w #(.WIDTH(8), .DEPTH(8), .BYPASS(1'b1)) u_dut8 (
    .CLK(clk), .RST_N(rst_n), .WEN(wen), .WADDR(waddr), .DIN(din),
    .REN0(ren0), .RADDR0(raddr0), .DOUT0(a_dout0), .RVALID0(a_rvalid0),
    .REN1(ren1), .RADDR1(raddr1), .DOUT1(a_dout1), .RVALID1(a_rvalid1),
    .CLR(clr), .BUSY(a_busy)
`ifdef REG_FILE_PARITY_EN
    , .PERR0(a_perr0), .PERR1(a_perr1)
`endif
  );

  reg_file_2r1w #(.WIDTH(8), .DEPTH(6), .BYPASS(1'b0)) u_dut6 (
    .CLK(clk), .RST_N(rst_n), .WEN(wen), .WADDR(waddr), .DIN(din),
    .REN0(ren0), .RADDR0(raddr0), .DOUT0(b_dout0), .RVALID0(b_rvalid0),
    .REN1(ren1), .RADDR1(raddr1), .DOUT1(b_dout1), .RVALID1(b_rvalid1),
    .CLR(clr), .BUSY(b_busy)
`ifdef REG_FILE_PARITY_EN
    , .PERR0(b_perr0), .PERR1(b_perr1)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end else begin
      $display("chk %s = %0h", nm, act);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic p);
    exp_t e;
    e.data = d;
    e.perr = p;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic mon(input int k, input string nm, input logic v, input logic [7:0] d, input logic p);
    exp_t e;
    if (v) begin
      total++;
      if (qsize(k) == 0) begin
        bad++;
        $display("FAIL %s unexpected rvalid: got dout=%02h, required no read", nm, d);
      end else begin
        case (k)
          0: e = q0.pop_front();
          1: e = q1.pop_front();
          2: e = q2.pop_front();
          default: e = q3.pop_front();
        endcase
        if (d !== e.data) begin
          bad++;
          $display("FAIL %s dout: got %02h, required %02h", nm, d, e.data);
        end else begin
          $display("rd %s dout=%02h", nm, d);
        end
`ifdef REG_FILE_PARITY_EN
        total++;
        if (p !== e.perr) begin
          bad++;
          $display("FAIL %s perr: got %0b, required %0b", nm, p, e.perr);
        end
`else
        if (p !== 1'b0) $display("note %s perr tied", nm);
`endif
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, "d8p0", a_rvalid0, a_dout0, a_perr0);
    mon(1, "d8p1", a_rvalid1, a_dout1, a_perr1);
    mon(2, "d6p0", b_rvalid0, b_dout0, b_perr0);
    mon(3, "d6p1", b_rvalid1, b_dout1, b_perr1);
  end

  task automatic step(input logic w, input logic [2:0] wa, input logic [7:0] d,
                      input logic r0, input logic [2:0] a0, input logic r1,
                      input logic [2:0] a1, input logic c);
    wen = w; waddr = wa; din = d; ren0 = r0; raddr0 = a0; ren1 = r1; raddr1 = a1; clr = c;
    @(posedge clk);
    #1;
    wen = 1'b0; waddr = '0; din = '0; ren0 = 1'b0; raddr0 = '0;
    ren1 = 1'b0; raddr1 = '0; clr = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    step(1'b1, a, d, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
  endtask

  // x* = expected from the DEPTH=8 instance, y* = from the DEPTH=6 instance.
  task automatic rd(input logic [2:0] a0, input logic [7:0] x0, input logic [7:0] y0,
                    input logic [2:0] a1, input logic [7:0] x1, input logic [7:0] y1);
    push(0, x0, 1'b0); push(1, x1, 1'b0); push(2, y0, 1'b0); push(3, y1, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b1, a0, 1'b1, a1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ba, bb;
    repeat (3) @(posedge clk);
    #1;
    check("reset d8 dout0", a_dout0, 0);
    check("reset d8 dout1", a_dout1, 0);
    check("reset d8 rvalid", {a_rvalid1, a_rvalid0}, 0);
    check("reset d6 rvalid", {b_rvalid1, b_rvalid0}, 0);
    check("reset busy", {b_busy, a_busy}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    rd(3'd3, 8'h00, 8'h00, 3'd7, 8'h00, 8'h00);
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    check("rvalid drops d8", {a_rvalid1, a_rvalid0}, 0);

    wr(3'd2, 8'hA5);
    wr(3'd5, 8'h3C);
    rd(3'd2, 8'hA5, 8'hA5, 3'd5, 8'h3C, 8'h3C);

    // Collision: the DEPTH=8 instance bypasses, the DEPTH=6 one returns old data.
    wr(3'd4, 8'h11);
    push(0, 8'h77, 1'b0);
    push(2, 8'h11, 1'b0);
    step(1'b1, 3'd4, 8'h77, 1'b1, 3'd4, 1'b0, 3'd0, 1'b0);
    rd(3'd4, 8'h77, 8'h77, 3'd4, 8'h77, 8'h77);

    wr(3'd6, 8'h55);
    rd(3'd6, 8'h55, 8'h00, 3'd0, 8'h00, 8'h00);

    for (int a = 0; a < 8; a++) wr(3'(a), 8'hFF);
    push(0, 8'hFF, 1'b0);
    push(2, 8'hFF, 1'b0);
    step(1'b1, 3'd0, 8'h12, 1'b1, 3'd2, 1'b0, 3'd0, 1'b1);
    ba = 0;
    bb = 0;
    for (int i = 0; i < 12; i++) begin
      if (a_busy) ba++;
      if (b_busy) bb++;
      if (i > 0 && i < 6) check("sweep rvalid low", {b_rvalid0, a_rvalid0}, 0);
      step(1'b0, 3'd0, 8'h00, (i < 6), 3'd3, 1'b0, 3'd0, 1'b0);
    end
    check("busy cycles d8", ba, 8);
    check("busy cycles d6", bb, 6);
    for (int a = 0; a < 8; a++) rd(3'(a), 8'h00, 8'h00, 3'(7 - a), 8'h00, 8'h00);

    wr(3'd1, 8'h42);
    wr(3'd7, 8'h99);
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    repeat (3) step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    check("busy mid sweep", a_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("busy after async reset", {b_busy, a_busy}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    check("idle after reset release", {b_busy, a_busy}, 0);
    rd(3'd7, 8'h00, 8'h00, 3'd1, 8'h00, 8'h00);

`ifdef REG_FILE_PARITY_EN
    wr(3'd1, 8'h01);
    force u_dut8.g_entry[1].par_reg = 1'b0;
    push(0, 8'h01, 1'b1); push(1, 8'h01, 1'b1);
    push(2, 8'h01, 1'b0); push(3, 8'h01, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b1, 3'd1, 1'b0);
    release u_dut8.g_entry[1].par_reg;
`endif

    repeat (3) step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    for (int k = 0; k < 4; k++) check("pending reads", qsize(k), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
